// File: rtl/mole_pkg.sv
// Shared state type, dwell limits and counter width for the mole dwell timer.
package mole_pkg;

  localparam int MWAIT_W = 3;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2,
    HIT     = 2'd3
  } mole_state_t;

  localparam logic [MWAIT_W-1:0] LIMIT_L0 = 3'd7;
  localparam logic [MWAIT_W-1:0] LIMIT_L1 = 3'd5;
  localparam logic [MWAIT_W-1:0] LIMIT_L2 = 3'd4;
  localparam logic [MWAIT_W-1:0] LIMIT_L3 = 3'd2;

  function automatic logic [MWAIT_W-1:0] dwell_limit(input logic [1:0] level);
    case (level)
      2'd0:    dwell_limit = LIMIT_L0;
      2'd1:    dwell_limit = LIMIT_L1;
      2'd2:    dwell_limit = LIMIT_L2;
      default: dwell_limit = LIMIT_L3;
    endcase
  endfunction

endpackage

// File: rtl/mole_hit_sync.sv
// Turns the raw player hit into a single-cycle hit_evt on its rising edge.
// Define MOLE_HIT_SYNC_EN to insert a 2-flop synchronizer ahead of the edge detector.
module mole_hit_sync (
  input  logic CLOCK_WAIT,
  input  logic Mreset_wait,
  input  logic hit,
  output logic hit_evt
);

  logic samp;
  logic primed;
  logic prev_q, prev_d;

`ifdef MOLE_HIT_SYNC_EN
  logic [1:0] sync_q, sync_d;
  logic [2:0] vld_q, vld_d;

  // vld_q marks when sync and prev hold real post-reset samples rather than reset zeros
  always_comb begin
    sync_d = {sync_q[0], hit};
    vld_d  = {vld_q[1:0], 1'b1};
  end

  always_ff @(posedge CLOCK_WAIT or posedge Mreset_wait) begin
    if (Mreset_wait) begin
      sync_q <= 2'b00;
      vld_q  <= 3'b000;
    end else begin
      sync_q <= sync_d;
      vld_q  <= vld_d;
    end
  end

  assign samp   = sync_q[1];
  assign primed = vld_q[2];
`else
  logic vld_q, vld_d;

  always_comb begin
    vld_d = 1'b1;
  end

  always_ff @(posedge CLOCK_WAIT or posedge Mreset_wait) begin
    if (Mreset_wait) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign samp   = hit;
  assign primed = vld_q;
`endif

  always_comb begin
    prev_d = samp;
  end

  always_ff @(posedge CLOCK_WAIT or posedge Mreset_wait) begin
    if (Mreset_wait) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // A hit already high when reset releases has no low prior sample, so it never fires
  assign hit_evt = samp & ~prev_q & primed;

endmodule

// File: rtl/mole_dwell_timer.sv
// Counts how long a fully raised mole stays up and reports expiry or a whack.
// Hit latency depends on MOLE_HIT_SYNC_EN (see mole_hit_sync).
module mole_dwell_timer
  import mole_pkg::*;
(
  input  logic               CLOCK_WAIT,
  input  logic               Mreset_wait,
  input  logic [1:0]         level,
  input  logic               pause,
  input  logic               hit,
  output logic [MWAIT_W-1:0] Mwait,
  output logic               dwell_done,
  output logic               whacked,
  output logic               hit_pulse
);

  mole_state_t        state_q, state_d;
  logic [MWAIT_W-1:0] mwait_q, mwait_d;
  logic [MWAIT_W-1:0] limit_q, limit_d;
  logic [MWAIT_W-1:0] mwait_inc;
  logic               hit_pulse_q, hit_pulse_d;
  logic               hit_evt;

  mole_hit_sync u_hit_sync (
    .CLOCK_WAIT  (CLOCK_WAIT),
    .Mreset_wait (Mreset_wait),
    .hit         (hit),
    .hit_evt     (hit_evt)
  );

  always_ff @(posedge CLOCK_WAIT or posedge Mreset_wait) begin
    if (Mreset_wait) begin
      state_q     <= ARM;
      mwait_q     <= '0;
      limit_q     <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mwait_q     <= mwait_d;
      limit_q     <= limit_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  // A hit event always beats both counting and expiry on the same edge
  always_comb begin
    state_d   = state_q;
    mwait_d   = mwait_q;
    limit_d   = limit_q;
    mwait_inc = mwait_q + MWAIT_W'(1);
    case (state_q)
      ARM: begin
        if (hit_evt) begin
          state_d = HIT;
        end else begin
          limit_d = dwell_limit(level);
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (hit_evt) begin
          state_d = HIT;
        end else if (!pause && (mwait_q != limit_q)) begin
          mwait_d = mwait_inc;
          if (mwait_inc == limit_q) begin
            state_d = EXPIRED;
          end
        end
      end
      default: begin
      end
    endcase
    hit_pulse_d = (state_d == HIT) && (state_q != HIT);
  end

  assign Mwait      = mwait_q;
  assign dwell_done = (state_q == EXPIRED) || (state_q == HIT);
  assign whacked    = (state_q == HIT);
  assign hit_pulse  = hit_pulse_q;

endmodule

// File: tb/tb_mole_dwell_timer.sv
// Self-checking bench for mole_dwell_timer: directed scenarios plus randomized dwells
// compared against an edge-by-edge behavioural model of the dwell rules.
module tb_mole_dwell_timer;

  logic       CLOCK_WAIT = 1'b0;
  logic       Mreset_wait;
  logic [1:0] level;
  logic       pause;
  logic       hit;
  logic [2:0] Mwait;
  logic       dwell_done;
  logic       whacked;
  logic       hit_pulse;

`ifdef MOLE_HIT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLOCK_WAIT = ~CLOCK_WAIT;

  mole_dwell_timer dut (
    .CLOCK_WAIT  (CLOCK_WAIT),
    .Mreset_wait (Mreset_wait),
    .level       (level),
    .pause       (pause),
    .hit         (hit),
    .Mwait       (Mwait),
    .dwell_done  (dwell_done),
    .whacked     (whacked),
    .hit_pulse   (hit_pulse)
  );

  // Reference model: hit history per edge since reset plus dwell bookkeeping
  int dwell_tab [4] = '{7, 5, 4, 2};
  bit hist [$];
  int edge_n;
  int m_count, m_limit;
  bit m_armed, m_done, m_whacked, m_pulse;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    edge_n    = 0;
    m_count   = 0;
    m_limit   = 0;
    m_armed   = 0;
    m_done    = 0;
    m_whacked = 0;
    m_pulse   = 0;
  endtask

  task automatic modelStep(input int lvl, input bit p, input bit h);
    int k;
    bit evt;
    hist.push_back(h);
    edge_n++;
    k   = edge_n - LAT;
    evt = (k >= 2) && hist[k-1] && !hist[k-2];
    m_pulse = 0;
    if (!m_done) begin
      if (evt) begin
        m_done    = 1;
        m_whacked = 1;
        m_pulse   = 1;
      end else if (!m_armed) begin
        m_armed = 1;
        m_limit = dwell_tab[lvl];
      end else if (!p) begin
        m_count++;
        if (m_count == m_limit) m_done = 1;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".Mwait"}, int'(Mwait), m_count);
    checkOutput({tag, ".dwell_done"}, int'(dwell_done), int'(m_done));
    checkOutput({tag, ".whacked"}, int'(whacked), int'(m_whacked));
    checkOutput({tag, ".hit_pulse"}, int'(hit_pulse), int'(m_pulse));
  endtask

  // Called at a negedge; drives inputs, takes one rising edge, checks, returns at next negedge
  task automatic applyStimulus(input int lvl, input bit p, input bit h, input string tag);
    level = 2'(lvl);
    pause = p;
    hit   = h;
    @(posedge CLOCK_WAIT);
    #1;
    modelStep(lvl, p, h);
    checkAll(tag);
    @(negedge CLOCK_WAIT);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases at a negedge
  task automatic resetDut();
    #2;
    Mreset_wait = 1'b1;
    #1;
    checkOutput("rst.Mwait", int'(Mwait), 0);
    checkOutput("rst.dwell_done", int'(dwell_done), 0);
    checkOutput("rst.whacked", int'(whacked), 0);
    checkOutput("rst.hit_pulse", int'(hit_pulse), 0);
    @(posedge CLOCK_WAIT);
    @(posedge CLOCK_WAIT);
    @(negedge CLOCK_WAIT);
    Mreset_wait = 1'b0;
    modelReset();
  endtask

  initial begin
    int lvl;
    bit p, h;
    Mreset_wait = 1'b1;
    level       = 2'd0;
    pause       = 1'b0;
    hit         = 1'b0;
    modelReset();
    @(negedge CLOCK_WAIT);

    // Level 2 free run: Mwait 0..4 on edges 1..5, then frozen
    resetDut();
    for (int e = 1; e <= 7; e++) begin
      applyStimulus(2, 0, 0, "lvl2");
      checkOutput("lvl2.seq", int'(Mwait), (e - 1 < 4) ? e - 1 : 4);
      checkOutput("lvl2.done", int'(dwell_done), (e >= 5) ? 1 : 0);
    end

    // Level latched at the ARM edge; later changes ignored
    resetDut();
    for (int e = 1; e <= 5; e++) begin
      applyStimulus((e == 1) ? 3 : 0, 0, 0, "latch");
      if (e == 3) begin
        checkOutput("latch.done3", int'(dwell_done), 1);
        checkOutput("latch.mwait3", int'(Mwait), 2);
      end
    end

    // Pause for three edges at Mwait=2 on level 0
    resetDut();
    for (int e = 1; e <= 13; e++) begin
      applyStimulus(0, (e >= 4 && e <= 6), 0, "pause");
      if (e == 6) checkOutput("pause.hold", int'(Mwait), 2);
      if (e == 10) checkOutput("pause.done10", int'(dwell_done), 0);
      if (e == 11) checkOutput("pause.done11", int'(dwell_done), 1);
    end

    // Hit raised at Mwait=2 on level 1; a second hit later is ignored
    resetDut();
    for (int e = 1; e <= 13; e++) begin
      h = (e >= 4 && e <= 5 + LAT) || (e >= 8 + LAT && e <= 9 + LAT);
      applyStimulus(1, 0, h, "whack");
      if (e == 4 + LAT) begin
        checkOutput("whack.whacked", int'(whacked), 1);
        checkOutput("whack.pulse", int'(hit_pulse), 1);
        checkOutput("whack.mwait", int'(Mwait), 2 + LAT);
      end
      if (e == 5 + LAT) checkOutput("whack.pulse_end", int'(hit_pulse), 0);
      if (e == 13) checkOutput("whack.frozen", int'(Mwait), 2 + LAT);
    end

    // Hit event on the same edge as the 3->4 expiry at level 2
    resetDut();
    for (int e = 1; e <= 7; e++) begin
      applyStimulus(2, 0, (e >= 5 - LAT), "tie");
      if (e == 5) begin
        checkOutput("tie.whacked", int'(whacked), 1);
        checkOutput("tie.mwait", int'(Mwait), 3);
        checkOutput("tie.done", int'(dwell_done), 1);
      end
    end

    // Reset mid-count with hit held high across release
    resetDut();
    for (int e = 1; e <= 3; e++) applyStimulus(1, 0, 0, "midrst");
    checkOutput("midrst.pre", int'(Mwait), 2);
    hit = 1'b1;
    resetDut();
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1, 0, 1, "held");
      checkOutput("held.nowhack", int'(whacked), 0);
    end
    checkOutput("held.mwait", int'(Mwait), 5);
    checkOutput("held.done", int'(dwell_done), 1);

    // Randomized dwells with toggling hit, random pause, level churn and rare resets
    for (int r = 0; r < 30; r++) begin
      lvl = int'($urandom_range(0, 3));
      h   = 0;
      hit = 1'b0;
      resetDut();
      for (int e = 0; e < 14; e++) begin
        if ($urandom_range(0, 3) == 0) h = ~h;
        p = ($urandom_range(0, 3) == 0);
        if (e > 0) lvl = int'($urandom_range(0, 3));
        if ($urandom_range(0, 24) == 0) resetDut();
        applyStimulus(lvl, p, h, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_dwell_timer.md
MOLE_DWELL_TIMER -- requirements
Module: mole_dwell_timer

Interface
REQ-001 SHALL have port CLOCK_WAIT  input  1  dwell tick clock; all state updates on its rising edge.
REQ-002 SHALL have port Mreset_wait  input  1  reset Mreset_wait, asynchronous, active-high; clock CLOCK_WAIT; held high by the mole FSM whenever the mole is not at full height.
REQ-003 SHALL have port level  input  2  difficulty level; selects the dwell limit.
REQ-004 SHALL have port pause  input  1  freezes dwell counting while high.
REQ-005 SHALL have port hit  input  1  raw whack request from the player input, asynchronous to CLOCK_WAIT.
REQ-006 SHALL have port Mwait  output  3  dwell tick count.
REQ-007 SHALL have port dwell_done  output  1  mole must retract; level signal.
REQ-008 SHALL have port whacked  output  1  mole retracted due to a hit; level signal.
REQ-009 SHALL have port hit_pulse  output  1  one-cycle pulse on entry to HIT, for the score block.

Function
REQ-010 SHALL implement states ARM, COUNT, EXPIRED, HIT.
REQ-011 SHALL map level to dwell limit: 0->7, 1->5, 2->4, 3->2.
REQ-012 ARM, first edge: SHALL latch the limit from level and go to COUNT with Mwait held at 0; this transition is not blocked by pause.
REQ-013 SHALL ignore level changes after the ARM edge until the next reset.
REQ-014 COUNT, pause low: SHALL set Mwait to Mwait+1 each edge; on the edge where Mwait+1 equals the latched limit, SHALL go to EXPIRED.
REQ-015 COUNT, pause high: SHALL hold Mwait and state.
REQ-016 EXPIRED and HIT: SHALL freeze Mwait; both are terminal until reset.
REQ-017 A hit event in ARM or COUNT SHALL move to HIT on that edge, regardless of pause.
REQ-018 A hit event in EXPIRED or HIT SHALL be ignored.
REQ-019 Hit event and expiry on the same edge: HIT SHALL win.
REQ-020 Hit event SHALL be the rising edge of synchronized hit; a held hit SHALL count as exactly one event.
REQ-021 Outputs SHALL be registered or decoded from state only:
  - dwell_done = EXPIRED or HIT
  - whacked = HIT
  - hit_pulse high exactly on the first cycle in HIT
REQ-022 Mwait SHALL never exceed 7 and SHALL never wrap.

Reset
REQ-023 Mreset_wait high SHALL force, immediately:
  - state ARM
  - Mwait 0, dwell_done 0, whacked 0, hit_pulse 0
  - synchronizer and edge-detect flops 0
REQ-024 Reset mid-COUNT or in a terminal state SHALL abandon the dwell with no output glitch other than the return to reset values.
REQ-025 A hit held high across reset release SHALL NOT produce a hit event.

Configuration
REQ-026 With MOLE_HIT_SYNC_EN defined, SHALL pass hit through a 2-flop synchronizer before edge detection; hit event latency is 2 edges after hit rises.
REQ-027 Without MOLE_HIT_SYNC_EN, SHALL feed hit directly to edge detection; latency is 0 edges, meaning an event is seen on the first edge where hit is high and its prior sample was low.

Structure
REQ-028 Package mole_pkg SHALL hold:
  - the state enum (ARM, COUNT, EXPIRED, HIT)
  - the dwell limit constants per level
  - the Mwait width constant 3
REQ-029 Sub-module mole_hit_sync SHALL contain the optional synchronizer and rising-edge detector, outputting hit_evt.

Verification
REQ-030 level=2, pause=0, no hit, release reset -> Mwait 0,1,2,3,4 on edges 1..5; dwell_done=1 from edge 5; Mwait frozen at 4.
REQ-031 level=3 latched, level changed to 0 after edge 1 -> dwell_done at edge 3 with Mwait=2.
REQ-032 level=0, pause high for 3 edges during COUNT at Mwait=2 -> Mwait holds 2; dwell_done at edge 11.
REQ-033 level=1, hit raised while Mwait=2, sync enabled -> whacked=1 and hit_pulse for one cycle two edges later; Mwait frozen; a second hit is ignored.
REQ-034 Hit event coincides with the Mwait 3->4 expiry edge at level 2 -> state HIT, whacked=1, Mwait=3.
REQ-035 Mreset_wait pulsed mid-COUNT with hit held high -> all outputs 0 asynchronously; no hit event after release; a fresh dwell completes normally.
